// File: rtl/async_single_port_ram.sv
// Small single-port scratch RAM: clocked writes, combinational reads, and one
// shared tri-state data bus that the RAM drives only while it is reading.
module async_single_port_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we_in,
    input  logic                  enable_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_write_en;
    logic                  we_and_en_s;
    logic                  w_read_en;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Asserting both strobes counts as idle, so the RAM never writes a value
    // it might itself be driving and never fights the master on the bus.
    assign we_and_en_s = we_in & enable_in;
    assign w_write_en  = we_in & ~enable_in;
    assign w_read_en   = enable_in & ~we_in & ~we_and_en_s;

    // Storage update: reset clears every word and wins over a same-edge write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_write_en) begin
            r_mem[addr_in] <= data;
        end
    end

    assign w_rdata = r_mem[addr_in];
    assign data    = w_read_en ? w_rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_async_single_port_ram.sv
// Self-checking bench for async_single_port_ram; a pull-up on the bus makes a
// released bus read as all ones, which is how high-Z is observed.
module tb_async_single_port_ram;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam logic [DW-1:0] FLOAT_VAL = 8'hFF;

    logic          clk_in;
    logic          rst_in;
    logic          we_in;
    logic          enable_in;
    logic [AW-1:0] addr_in;
    wire  [DW-1:0] data;

    logic          tb_drive_en;
    logic [DW-1:0] tb_drive_val;

    logic [DW-1:0] mdl [DP];
    logic [DW-1:0] exp_q [$];

    int test_cnt;
    int fail_cnt;

    async_single_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .we_in     (we_in),
        .enable_in (enable_in),
        .addr_in   (addr_in),
        .data      (data)
    );

    assign data = tb_drive_en ? tb_drive_val : {DW{1'bz}};

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup pu_i (data[g]);
    end

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Watchdog so a broken run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic sample_expected(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            test_cnt++;
            fail_cnt++;
            $display("FAIL %s: scoreboard empty got 0x%02h expected queued value", tag, data);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, data, e);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        tb_drive_en = 1'b0;
        we_in       = 1'b0;
        enable_in   = 1'b1;
        addr_in     = a;
        exp_q.push_back(mdl[a]);
        #1;
        sample_expected(tag);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v, input bit chk_z);
        tb_drive_en = 1'b0;
        we_in       = 1'b1;
        enable_in   = 1'b0;
        addr_in     = a;
        #1;
        if (chk_z) begin
            exp_q.push_back(FLOAT_VAL);
            sample_expected($sformatf("wr_z_a%0d", a));
        end
        tb_drive_val = v;
        tb_drive_en  = 1'b1;
        @(posedge clk_in);
        #1;
        mdl[a]      = v;
        tb_drive_en = 1'b0;
        we_in       = 1'b0;
    endtask

    initial begin
        test_cnt     = 0;
        fail_cnt     = 0;
        tb_drive_en  = 1'b0;
        tb_drive_val = 8'h00;
        rst_in       = 1'b1;
        we_in        = 1'b0;
        enable_in    = 1'b0;
        addr_in      = 4'd0;
        for (int i = 0; i < DP; i++) mdl[i] = 8'h00;

        // Reset clear
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < DP; i++) do_read(i[AW-1:0], $sformatf("rst_clr_a%0d", i));

        // Sequential write, then read back
        @(posedge clk_in);
        #1;
        for (int i = 0; i < DP; i++) do_write(i[AW-1:0], i[DW-1:0], (i % 4) == 0);
        for (int i = 0; i < DP; i++) do_read(i[AW-1:0], $sformatf("seq_rd_a%0d", i));

        // Async read between edges
        @(negedge clk_in);
        do_read(4'd3, "async_a3");
        do_read(4'd9, "async_a9");
        do_read(4'd3, "async_a3_back");

        // Idle: bus floats
        enable_in = 1'b0;
        we_in     = 1'b0;
        addr_in   = 4'd3;
        #1;
        exp_q.push_back(FLOAT_VAL);
        sample_expected("idle_z");

        // Conflict: no write, RAM releases the bus
        @(posedge clk_in);
        #1;
        we_in        = 1'b1;
        enable_in    = 1'b1;
        addr_in      = 4'd5;
        tb_drive_val = 8'hAA;
        tb_drive_en  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        tb_drive_en = 1'b0;
        #1;
        exp_q.push_back(FLOAT_VAL);
        sample_expected("conflict_z");
        @(posedge clk_in);
        #1;
        do_read(4'd5, "conflict_keep_a5");

        // Overwrite and address boundaries
        do_write(4'd15, 8'hFF, 1'b0);
        do_write(4'd0, 8'h80, 1'b1);
        do_read(4'd15, "ovw_a15");
        do_read(4'd0, "ovw_a0");
        do_read(4'd14, "ovw_a14_keep");
        check_val("model_a15", mdl[15], 8'hFF);

        // Reset during read: old word until the edge, zero after
        do_write(4'd2, 8'h3C, 1'b0);
        we_in     = 1'b0;
        enable_in = 1'b1;
        addr_in   = 4'd2;
        rst_in    = 1'b1;
        #1;
        exp_q.push_back(8'h3C);
        sample_expected("rst_rd_before");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = 8'h00;
        exp_q.push_back(8'h00);
        sample_expected("rst_rd_after");

        // Reset priority over a same-edge write
        do_write(4'd7, 8'h77, 1'b0);
        do_read(4'd7, "pre_prio_a7");
        enable_in    = 1'b0;
        we_in        = 1'b1;
        addr_in      = 4'd7;
        tb_drive_val = 8'h55;
        tb_drive_en  = 1'b1;
        rst_in       = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in      = 1'b0;
        we_in       = 1'b0;
        tb_drive_en = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = 8'h00;
        do_read(4'd7, "rst_prio_a7");
        do_read(4'd15, "rst_prio_a15");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
